imm_const_loader: RTL and testbench

- Inverse of the immediate sign-extension path: takes a 32-bit constant and a destination register, and emits the minimal NIOS II I-type instruction sequence that loads that constant.
- Output is a 1- or 2-word stream. Each word carries a 16-bit immediate in IMM16[21:6], with A[31:27], B[26:22] and OP[5:0].
- Sits between the constant/literal source (boot ROM patcher, test sequencer) and the instruction memory write port.
- Valid/ready handshakes on both sides.

---
 rtl/imm_const_loader.sv | 88 ++++++++
 tb/tb_imm_const_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/imm_const_loader.sv
// imm_const_loader: emits the shortest addi/orhi/ori sequence that loads a 32-bit constant into rB
module imm_const_loader #(
  parameter logic [5:0] OP_ADDI = 6'h04,
  parameter logic [5:0] OP_ORHI = 6'h34,
  parameter logic [5:0] OP_ORI  = 6'h14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] const_in,
  input  logic [4:0]  dest_reg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_word,
  output logic        inst_last,
  output logic        drop
);
  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
  state_t state;
  logic [31:0] val;
  logic [4:0] dst;
  logic two;
  logic fits, hi_zero, lo_zero, two_in;
  logic [15:0] imm1;
  logic [5:0] op1;
  logic [31:0] word1, word2;
  always_comb begin
    fits = &const_in[31:15] || ~|const_in[31:15];
    hi_zero = ~|const_in[31:16];
    lo_zero = ~|const_in[15:0];
    two_in = !fits && !hi_zero && !lo_zero;
    imm1 = (fits || hi_zero) ? const_in[15:0] : const_in[31:16];
    op1 = fits ? OP_ADDI : lo_zero ? OP_ORHI : hi_zero ? OP_ORI : OP_ORHI;
    word1 = {5'd0, dest_reg, imm1, op1};
    word2 = {dst, dst, val[15:0], OP_ORI};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      inst_word <= '0;
      inst_last <= 1'b0;
      drop <= 1'b0;
      val <= '0;
      dst <= '0;
      two <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          val <= const_in;
          dst <= dest_reg;
          two <= two_in;
          if (dest_reg != 5'd0) begin
            state <= EMIT1;
            in_ready <= 1'b0;
            out_valid <= 1'b1;
            inst_word <= word1;
            inst_last <= !two_in;
          end else drop <= 1'b1;
        end
        EMIT1: if (out_ready) begin
          if (two) begin
            state <= EMIT2;
            inst_word <= word2;
            inst_last <= 1'b1;
          end else begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            inst_word <= '0;
            inst_last <= 1'b0;
          end
        end
        EMIT2: if (out_ready) begin
          state <= IDLE;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
          inst_word <= '0;
          inst_last <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_const_loader.sv
// tb_imm_const_loader: random and directed constants checked against a reference model and an instruction executor
module tb_imm_const_loader;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] const_in = '0;
  logic [4:0] dest_reg = '0;
  logic in_ready, out_valid, inst_last, drop;
  logic [31:0] inst_word;
  int checks = 0, passed = 0;

  imm_const_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .const_in(const_in), .dest_reg(dest_reg), .out_valid(out_valid), .out_ready(out_ready),
    .inst_word(inst_word), .inst_last(inst_last), .drop(drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] a, input logic [4:0] b, input logic [15:0] imm, input logic [5:0] op);
    return {a, b, imm, op};
  endfunction

  // expected sequence chosen by the "shortest loader" rules, as a list of instruction words
  task automatic model(input logic [31:0] v, input logic [4:0] d, output logic [31:0] w[$]);
    int sv = int'(v);
    w = {};
    if (sv >= -32768 && sv <= 32767) w.push_back(enc(0, d, v[15:0], 6'h04));
    else if (v[15:0] == 16'h0) w.push_back(enc(0, d, v[31:16], 6'h34));
    else if (v[31:16] == 16'h0) w.push_back(enc(0, d, v[15:0], 6'h14));
    else begin
      w.push_back(enc(0, d, v[31:16], 6'h34));
      w.push_back(enc(d, d, v[15:0], 6'h14));
    end
  endtask

  // run the emitted program on a register file with r0 hardwired to zero
  function automatic logic [31:0] execute(input logic [31:0] w[$], input logic [4:0] d);
    logic [31:0] r[32];
    foreach (r[i]) r[i] = 32'hDEADBEEF;
    r[0] = 0;
    foreach (w[i]) begin
      logic [4:0] a = w[i][31:27], b = w[i][26:22];
      logic [15:0] imm = w[i][21:6];
      logic [31:0] ra = (a == 0) ? 32'h0 : r[a];
      case (w[i][5:0])
        6'h04: r[b] = ra + {{16{imm[15]}}, imm};
        6'h14: r[b] = ra | {16'h0, imm};
        6'h34: r[b] = ra | {imm, 16'h0};
        default: r[b] = 32'hBADC0DE0;
      endcase
    end
    return r[d];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [31:0] v, input logic [4:0] d);
    wait_ready();
    in_valid = 1'b1; const_in = v; dest_reg = d;
    tick();
    in_valid = 1'b0; const_in = $urandom; dest_reg = 5'($urandom);
  endtask

  task automatic send(input logic [31:0] v, input logic [4:0] d, input int max_stall);
    logic [31:0] exp[$], seen[$];
    model(v, d, exp);
    accept(v, d);
    if (d == 0) begin
      chk("drop_pulse", 32'(drop), 32'd1);
      chk("drop_no_valid", 32'(out_valid), 32'd0);
      chk("drop_ready", 32'(in_ready), 32'd1);
      tick();
      chk("drop_single", 32'(drop), 32'd0);
      return;
    end
    foreach (exp[i]) begin
      int st = $urandom_range(0, max_stall);
      for (int s = 0; s <= st; s++) begin
        out_ready = (s == st);
        chk("valid", 32'(out_valid), 32'd1);
        chk("word", inst_word, exp[i]);
        chk("last", 32'(inst_last), 32'(i == exp.size() - 1));
        chk("busy", 32'(in_ready), 32'd0);
        chk("no_drop", 32'(drop), 32'd0);
        if (s == st) seen.push_back(inst_word);
        tick();
      end
    end
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_last", 32'(inst_last), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("roundtrip", execute(seen, d), v);
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", inst_word, 32'd0);
    chk("rst_last", 32'(inst_last), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    reset = 1'b0;
    tick();
    send(32'h00001234, 5'd3, 0);
    send(32'hFFFF8000, 5'd3, 0);
    send(32'h12340000, 5'd5, 0);
    send(32'h0000ABCD, 5'd7, 0);
    send(32'h00000000, 5'd9, 0);
    send(32'h00008000, 5'd4, 1);
    send(32'h80000000, 5'd6, 1);
    send(32'h00007FFF, 5'd8, 1);
    send(32'hFFFFFFFF, 5'd31, 1);
    // two-word case with fixed stalls
    accept(32'h12345678, 5'd2);
    for (int s = 0; s < 4; s++) begin
      out_ready = (s == 3);
      chk("tw_w1", inst_word, 32'h00848D34);
      chk("tw_l1", 32'(inst_last), 32'd0);
      chk("tw_busy1", 32'(in_ready), 32'd0);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      out_ready = (s == 2);
      chk("tw_w2", inst_word, 32'h10959E14);
      chk("tw_l2", 32'(inst_last), 32'd1);
      chk("tw_busy2", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b0;
    chk("tw_done", 32'(out_valid), 32'd0);
    send(32'hCAFEF00D, 5'd0, 0);
    // reset while the second word is pending
    accept(32'h12345678, 5'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_rst_w2", inst_word, 32'h10959E14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_last", 32'(inst_last), 32'd0);
    tick();
    chk("abort_quiet", 32'(out_valid), 32'd0);
    accept(32'h00000000, 5'd1);
    chk("post_rst_word", inst_word, 32'h00400004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_idle", 32'(in_ready), 32'd1);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = {{16{1'b0}}, 16'($urandom)} | 32'(($urandom & 1) ? 32'hFFFF8000 : 0);
        1: v = {16'($urandom), 16'h0};
        2: v = {16'h0, 16'($urandom)};
        default: v = $urandom;
      endcase
      send(v, 5'($urandom_range(0, 31)), 3);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
